// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one request at a time to an external ALU. It waits
// ALU_LAT cycles per ALU use and returns the captured result through a
// valid/ready response port. MULT runs as a shift-and-add loop of ADD steps
// on the same ALU. Illegal modes return an error response without using the ALU.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready       request handshake
//   i_ALUmode, i_A, i_B,    request operands
//   i_Imm_SignExt, i_NPC
//   o_alu_*                 operands driven to the ALU (held in IDLE and RESP)
//   i_alu_ALUOutput,        ALU return values
//   i_alu_branch,
//   i_alu_retaddr
//   o_valid / i_res_ready   response handshake; o_result, o_branch, o_retaddr, o_err
//   i_flush                 abort any in-flight operation
//   o_busy                  high whenever not IDLE
module alu_issue_ctrl #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [5:0]  i_ALUmode,
   input  logic [31:0] i_A,
   input  logic [31:0] i_B,
   input  logic [31:0] i_Imm_SignExt,
   input  logic [31:0] i_NPC,
   output logic [5:0]  o_alu_ALUmode,
   output logic [31:0] o_alu_A,
   output logic [31:0] o_alu_B,
   output logic [31:0] o_alu_Imm_SignExt,
   output logic [31:0] o_alu_NPC,
   input  logic [31:0] i_alu_ALUOutput,
   input  logic        i_alu_branch,
   input  logic [31:0] i_alu_retaddr,
   output logic        o_valid,
   output logic [31:0] o_result,
   output logic        o_branch,
   output logic [31:0] o_retaddr,
   output logic        o_err,
   input  logic        i_res_ready,
   input  logic        i_flush,
   output logic        o_busy
);

   typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

   localparam logic [5:0] ModeAdd  = 6'd2;
   localparam logic [5:0] ModeMult = 6'd6;
   localparam logic [5:0] ModeLast = 6'd20;
   localparam logic [1:0] LatLast  = 2'(ALU_LAT - 1);

   state_e      state_q, state_d;
   logic [1:0]  lat_cnt_q;
   logic [4:0]  mul_cnt_q;
   logic [31:0] mplier_q;
   logic [5:0]  alu_mode_q;
   logic [31:0] alu_a_q, alu_b_q, alu_imm_q, alu_npc_q;
   logic [31:0] result_q, retaddr_q;
   logic        branch_q, err_q;

   logic        accept, mode_legal, step_end, mul_done;
   logic [31:0] mplier_shift, acc_next;

   assign accept       = i_valid & o_ready;
   assign mode_legal   = (i_ALUmode <= ModeLast);
   assign step_end     = (lat_cnt_q == LatLast);
   assign mplier_shift = mplier_q >> 1;
   // Last step: no multiplier bits remain, or all 32 bits have been consumed.
   assign mul_done     = (mplier_shift == 32'd0) || (mul_cnt_q == 5'd31);
   // During MUL the ALU computes acc + mcand; keep it only if the current bit is set.
   assign acc_next     = mplier_q[0] ? i_alu_ALUOutput : alu_a_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!mode_legal)                state_d = StResp;
               else if (i_ALUmode == ModeMult) state_d = StMul;
               else                            state_d = StExec;
            end
         end
         StExec: begin
            if (i_flush)       state_d = StIdle;
            else if (step_end) state_d = StResp;
         end
         StMul: begin
            if (i_flush)                   state_d = StIdle;
            else if (step_end && mul_done) state_d = StResp;
         end
         StResp: begin
            if (i_flush || i_res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= StIdle;
         lat_cnt_q  <= '0;
         mul_cnt_q  <= '0;
         mplier_q   <= '0;
         alu_mode_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_imm_q  <= '0;
         alu_npc_q  <= '0;
         result_q   <= '0;
         retaddr_q  <= '0;
         branch_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  lat_cnt_q <= '0;
                  mul_cnt_q <= '0;
                  if (!mode_legal) begin
                     // ALU drive registers are deliberately left untouched.
                     result_q  <= '0;
                     branch_q  <= 1'b0;
                     retaddr_q <= '0;
                     err_q     <= 1'b1;
                  end else if (i_ALUmode == ModeMult) begin
                     // alu_a_q doubles as the accumulator, alu_b_q as the multiplicand.
                     alu_mode_q <= ModeAdd;
                     alu_a_q    <= '0;
                     alu_b_q    <= i_A;
                     alu_imm_q  <= i_Imm_SignExt;
                     alu_npc_q  <= i_NPC;
                     mplier_q   <= i_B;
                  end else begin
                     alu_mode_q <= i_ALUmode;
                     alu_a_q    <= i_A;
                     alu_b_q    <= i_B;
                     alu_imm_q  <= i_Imm_SignExt;
                     alu_npc_q  <= i_NPC;
                  end
               end
            end
            StExec: begin
               if (!i_flush) begin
                  if (step_end) begin
                     lat_cnt_q <= '0;
                     result_q  <= i_alu_ALUOutput;
                     branch_q  <= i_alu_branch;
                     retaddr_q <= i_alu_retaddr;
                     err_q     <= 1'b0;
                  end else begin
                     lat_cnt_q <= lat_cnt_q + 2'd1;
                  end
               end
            end
            StMul: begin
               if (!i_flush) begin
                  if (step_end) begin
                     lat_cnt_q <= '0;
                     alu_a_q   <= acc_next;
                     alu_b_q   <= alu_b_q << 1;
                     mplier_q  <= mplier_shift;
                     mul_cnt_q <= mul_cnt_q + 5'd1;
                     if (mul_done) begin
                        result_q  <= acc_next;
                        branch_q  <= 1'b0;
                        retaddr_q <= '0;
                        err_q     <= 1'b0;
                     end
                  end else begin
                     lat_cnt_q <= lat_cnt_q + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready           = (state_q == StIdle) && !i_flush && !i_reset;
   assign o_busy            = (state_q != StIdle);
   assign o_valid           = (state_q == StResp);
   // Response fields read as zero outside RESP so reset and flush clear them at once.
   assign o_result          = o_valid ? result_q  : '0;
   assign o_branch          = o_valid ? branch_q  : 1'b0;
   assign o_retaddr         = o_valid ? retaddr_q : '0;
   assign o_err             = o_valid ? err_q     : 1'b0;
   assign o_alu_ALUmode     = alu_mode_q;
   assign o_alu_A           = alu_a_q;
   assign o_alu_B           = alu_b_q;
   assign o_alu_Imm_SignExt = alu_imm_q;
   assign o_alu_NPC         = alu_npc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with ALU_LAT=1 and a combinational
// ALU model. Expected responses are queued when a request is driven and popped
// when o_valid is seen. Cycle k is observed at the falling edge after k rising
// edges counted from the accept edge (cycle 0).
module tb_alu_issue_ctrl;

   localparam int unsigned ALU_LAT = 1;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [5:0]  i_ALUmode;
   logic [31:0] i_A, i_B, i_Imm_SignExt, i_NPC;
   logic [5:0]  o_alu_ALUmode;
   logic [31:0] o_alu_A, o_alu_B, o_alu_Imm_SignExt, o_alu_NPC;
   logic [31:0] i_alu_ALUOutput;
   logic        i_alu_branch;
   logic [31:0] i_alu_retaddr;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_branch;
   logic [31:0] o_retaddr;
   logic        o_err;
   logic        i_res_ready;
   logic        i_flush;
   logic        o_busy;

   alu_issue_ctrl #(.ALU_LAT(ALU_LAT)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_ALUmode(i_ALUmode), .i_A(i_A), .i_B(i_B), .i_Imm_SignExt(i_Imm_SignExt),
      .i_NPC(i_NPC), .o_alu_ALUmode(o_alu_ALUmode), .o_alu_A(o_alu_A), .o_alu_B(o_alu_B),
      .o_alu_Imm_SignExt(o_alu_Imm_SignExt), .o_alu_NPC(o_alu_NPC),
      .i_alu_ALUOutput(i_alu_ALUOutput), .i_alu_branch(i_alu_branch),
      .i_alu_retaddr(i_alu_retaddr), .o_valid(o_valid), .o_result(o_result),
      .o_branch(o_branch), .o_retaddr(o_retaddr), .o_err(o_err),
      .i_res_ready(i_res_ready), .i_flush(i_flush), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] alu_res(input logic [5:0] m, input logic [31:0] a, b, imm,
                                           npc);
      case (m)
         6'd2:    return a + b;
         6'd3:    return a + imm;
         6'd4:    return a - b;
         6'd7:    return a & b;
         6'd9:    return a | b;
         6'd16:   return a - b;
         6'd20:   return npc;
         default: return a + b;
      endcase
   endfunction

   function automatic logic alu_br(input logic [5:0] m, input logic [31:0] a, b);
      return (m == 6'd16 && a == b) || (m == 6'd20);
   endfunction

   // Combinational ALU model driven by the DUT's ALU outputs.
   always_comb begin
      i_alu_ALUOutput = alu_res(o_alu_ALUmode, o_alu_A, o_alu_B, o_alu_Imm_SignExt, o_alu_NPC);
      i_alu_branch    = alu_br(o_alu_ALUmode, o_alu_A, o_alu_B);
      i_alu_retaddr   = o_alu_NPC + 32'd4;
   end

   typedef struct {
      logic [31:0] result;
      logic        branch;
      logic [31:0] retaddr;
      logic        err;
      int          cycle;
   } exp_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic [5:0]  last_alu_mode = 6'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic run_op(input logic [5:0] mode, input logic [31:0] a, b, imm, npc,
                         input int hold_n);
      exp_t        e;
      exp_t        got;
      int          k;
      int          n;
      logic [5:0]  exp_alu_mode;
      logic [31:0] keep;
      if (mode > 6'd20) begin
         e.result = 0; e.branch = 0; e.retaddr = 0; e.err = 1; e.cycle = 1;
         exp_alu_mode = last_alu_mode;
      end else if (mode == 6'd6) begin
         n = 0;
         for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
         if (n == 0) n = 1;
         e.result = a * b; e.branch = 0; e.retaddr = 0; e.err = 0;
         e.cycle = n * ALU_LAT + 1;
         exp_alu_mode = 6'd2;
      end else begin
         e.result = alu_res(mode, a, b, imm, npc); e.branch = alu_br(mode, a, b);
         e.retaddr = npc + 32'd4; e.err = 0; e.cycle = ALU_LAT + 1;
         exp_alu_mode = mode;
      end
      sb.push_back(e);
      last_alu_mode = exp_alu_mode;
      @(negedge i_clk);
      i_valid = 1'b1; i_ALUmode = mode; i_A = a; i_B = b; i_Imm_SignExt = imm; i_NPC = npc;
      #1 chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      k = 1;
      i_valid = 1'b0;
      chk("alu_mode_cycle1", {26'd0, o_alu_ALUmode}, {26'd0, exp_alu_mode});
      while (o_valid !== 1'b1 && k < 200) begin
         @(negedge i_clk);
         k++;
      end
      got = sb.pop_front();
      chk("latency", k, got.cycle);
      chk("result", o_result, got.result);
      chk("branch", {31'd0, o_branch}, {31'd0, got.branch});
      chk("retaddr", o_retaddr, got.retaddr);
      chk("err", {31'd0, o_err}, {31'd0, got.err});
      keep = o_result;
      for (int h = 0; h < hold_n; h++) begin
         @(negedge i_clk);
         chk("hold_valid", {31'd0, o_valid}, 32'd1);
         chk("hold_result", o_result, keep);
         chk("hold_ready", {31'd0, o_ready}, 32'd0);
      end
      i_res_ready = 1'b1;
      @(negedge i_clk);
      i_res_ready = 1'b0;
      chk("after_resp_valid", {31'd0, o_valid}, 32'd0);
      chk("after_resp_ready", {31'd0, o_ready}, 32'd1);
   endtask

   // Starts MULT with B=0xFFFF and aborts it at cycle 10 by flush or reset.
   task automatic abort_mult(input bit use_reset);
      int   k;
      logic seen;
      seen = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b1; i_ALUmode = 6'd6; i_A = 32'd3; i_B = 32'h0000_FFFF;
      @(posedge i_clk);
      @(negedge i_clk);
      k = 1;
      i_valid = 1'b0;
      while (k < 10) begin
         seen = seen | o_valid;
         @(negedge i_clk);
         k++;
      end
      seen = seen | o_valid;
      chk("busy_before_abort", {31'd0, o_busy}, 32'd1);
      if (use_reset) begin
         i_reset = 1'b1;
         #1;
         chk("rst_busy", {31'd0, o_busy}, 32'd0);
         chk("rst_valid", {31'd0, o_valid}, 32'd0);
         chk("rst_ready", {31'd0, o_ready}, 32'd0);
         chk("rst_alu_mode", {26'd0, o_alu_ALUmode}, 32'd0);
         chk("rst_alu_a", o_alu_A, 32'd0);
         chk("rst_alu_b", o_alu_B, 32'd0);
         last_alu_mode = 6'd0;
         @(negedge i_clk);
         i_reset = 1'b0;
         #1 chk("rst_release_ready", {31'd0, o_ready}, 32'd1);
      end else begin
         i_flush = 1'b1;
         @(negedge i_clk);
         chk("flush_idle_c11", {31'd0, o_busy}, 32'd0);
         i_flush = 1'b0;
         #1 chk("flush_ready", {31'd0, o_ready}, 32'd1);
         last_alu_mode = 6'd2;
      end
      repeat (4) begin
         @(negedge i_clk);
         seen = seen | o_valid;
      end
      chk(use_reset ? "rst_no_response" : "flush_no_response", {31'd0, seen}, 32'd0);
   endtask

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_ALUmode = '0; i_A = '0; i_B = '0;
      i_Imm_SignExt = '0; i_NPC = '0; i_res_ready = 1'b0; i_flush = 1'b0;
      #1;
      chk("reset_ready", {31'd0, o_ready}, 32'd0);
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_alu_a", o_alu_A, 32'd0);
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      #1 chk("ready_after_reset", {31'd0, o_ready}, 32'd1);

      run_op(6'd2, 32'd5, 32'd7, 32'd0, 32'h100, 0);
      run_op(6'd6, 32'd3, 32'd5, 32'd0, 32'h0, 0);
      run_op(6'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h0, 0);
      run_op(6'd6, 32'h1234_5678, 32'd0, 32'd0, 32'h0, 0);
      run_op(6'h3F, 32'd9, 32'd9, 32'd0, 32'h0, 0);
      run_op(6'd16, 32'd42, 32'd42, 32'd0, 32'h200, 5);
      run_op(6'd4, 32'd10, 32'd25, 32'd0, 32'h300, 0);
      run_op(6'd3, 32'd100, 32'd0, 32'hFFFF_FFF0, 32'h0, 1);
      run_op(6'd6, 32'h0001_0003, 32'h0000_0107, 32'd0, 32'h0, 0);
      run_op(6'd21, 32'd1, 32'd2, 32'd3, 32'd4, 0);

      // Flush in IDLE blocks acceptance for that cycle only.
      @(negedge i_clk);
      i_flush = 1'b1; i_valid = 1'b1; i_ALUmode = 6'd2;
      #1 chk("flush_idle_ready", {31'd0, o_ready}, 32'd0);
      @(negedge i_clk);
      i_valid = 1'b0; i_flush = 1'b0;
      chk("flush_idle_busy", {31'd0, o_busy}, 32'd0);

      // Flush in RESP drops the response even with i_res_ready high.
      @(negedge i_clk);
      i_valid = 1'b1; i_ALUmode = 6'd7; i_A = 32'hF0F0; i_B = 32'hFF00;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("resp_before_flush", {31'd0, o_valid}, 32'd1);
      chk("resp_and_result", o_result, 32'h0000_F000);
      i_flush = 1'b1; i_res_ready = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0; i_res_ready = 1'b0;
      chk("resp_flush_valid", {31'd0, o_valid}, 32'd0);
      chk("resp_flush_busy", {31'd0, o_busy}, 32'd0);
      last_alu_mode = 6'd7;

      abort_mult(1'b0);
      abort_mult(1'b1);
      run_op(6'd9, 32'h0F, 32'hF0, 32'd0, 32'h40, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
